rsa_modexp_param: RTL
=====================

// Module: rsa_modexp_param
// PURPOSE
// - Parametrised modular exponentiator for the DE2 RSA datapath: result = M^E mod N.
// - Uses a radix-2 Montgomery core: two multipliers run in parallel, with right-to-left square-and-multiply.
// - Shares the existing byte-wide reg_sel/addr host bus, so the NIOS/host driver is unchanged.
// - Adds busy/done/err status, operand checking and a correct exit from the Montgomery domain.
// PARAMETERS
// - KEY_W   256  modulus/base width in bits; multiple of 8, >=16
// - EXP_W   256  exponent width in bits; multiple of 8
// - ADDR_W  5    byte-address width; requires 8*2^ADDR_W >= max(KEY_W,EXP_W)
// PORTS
// - clk      in   1       single clock, rising edge
// - reset    in   1       asynchronous, active-low; all state cleared while low
// - we       in   1       active-low byte write strobe, sampled at clk
// - oe       in   1       active-low byte read strobe, sampled at clk
// - start    in   1       active-high; sampled only in IDLE
// - reg_sel  in   2       0=result(read) 1=M base 2=E exponent 3=N modulus
// - addr     in   ADDR_W  byte index; byte b = bits [8b+7:8b]
// - data_i   in   8       write data
// - data_o   out  8       registered read data
// - busy     out  1       high from the cycle after an accepted start until done
// - done     out  1       one-cycle pulse when result is valid or err is set
// - err      out  1       sticky operand error; cleared by the next accepted start
// BEHAVIOUR
// - Reset values: data_o=0, busy=0, done=0, err=0, result=0, M=E=N=0, FSM=IDLE.
// - Host writes (we=0, reg_sel 1..3): byte addr of the operand is loaded.
//   - Bytes beyond the operand width are ignored.
//   - Writes while busy=1 are ignored.
// - Host reads (oe=0, reg_sel 0): data_o <= result byte addr one cycle later; bytes beyond KEY_W read 0.
//   - Reads are allowed while busy and return the previous result.
// - If we=0 and oe=0 together, the write wins and data_o holds its value.
// - start in IDLE with any operand error -> err=1, done pulse next cycle, result unchanged, no compute.
//   - Operand errors: N[0]=0, N<3, or M>=N.
// - start while busy is ignored.
// - FSM: IDLE -> PRE -> MONT -> EXP -> OUT -> IDLE.
// - PRE: c = R^2 mod N, with R = 2^(KEY_W+2).
//   - Computed by shift-and-conditional-subtract from 1.
//   - 2*KEY_W+4 cycles.
// - MM(a,b) = a*b*R^-1 mod N.
//   - Each cycle: KEY_W+2 iterations of S = (S + a_i*b + q*N) >> 1, with q = LSB of (S + a_i*b).
//   - Then one final-subtract cycle.
//   - Total KEY_W+3 cycles; output < N.
//   - Internal accumulator width KEY_W+3.
// - MONT: in parallel, t = MM(M,c) and x = MM(1,c) = R mod N. One MM time.
// - EXP: per exponent bit, LSB first. In parallel:
//   - x = MM(x,t) if the bit is 1, else x holds.
//   - t = MM(t,t).
//   - One MM time per bit.
// - OUT: result = MM(x,1). busy falls and done pulses in the cycle result is written.
// - Latency from start to done, without the macro: (2*KEY_W+4) + (EXP_W+2)*(KEY_W+3) cycles.
// - E=0 -> result=1.
// - Reset low mid-operation aborts immediately: no done, result returns to 0.
// CONFIGURATION
// - RSA_EXP_SKIP_EN defined:
//   - EXP ends once the remaining (shifted) exponent is 0.
//   - Latency becomes (2*KEY_W+4) + (L+2)*(KEY_W+3), with L = index of the highest set bit of E, plus 1.
//   - For E=0, L=0.
// - RSA_EXP_SKIP_EN undefined: always EXP_W iterations; latency is data-independent (timing-attack safe).
// - The result is identical in both builds.
// TESTING (KEY_W=16, EXP_W=16, ADDR_W=1)
// - Basic: N=497, M=4, E=13, start.
//   - result=445.
//   - Without macro: done exactly 378 cycles after start.
//   - With RSA_EXP_SKIP_EN: done after 150 cycles.
// - Fermat: N=65521, M=2, E=65520 -> result=1, err=0.
// - Zero exponent: N=497, M=123, E=0 -> result=1.
// - Errors, each followed by start:
//   - N=0x01F0 -> err=1, done 1 cycle after start, result unchanged.
//   - N=497, M=497 -> err=1.
//   - A valid start afterwards clears err.
// - Bus during busy:
//   - Write N=1000 mid-run -> ignored; result still 445.
//   - Read byte 0 mid-run -> old result byte.
//   - start pulse mid-run -> ignored, with no extra done.
// - Reset: assert reset low at cycle 100 of a run.
//   - busy=0, done=0, data_o=0 immediately.
//   - After release, reload operands and rerun -> 445.

Source files
------------

// File: rtl/rsa_modexp_param.sv
// M^E mod N via radix-2 Montgomery (two MM units in parallel, right-to-left square-and-multiply).
// Define RSA_EXP_SKIP_EN to end the exponent scan at the top set bit; this makes latency data-dependent.
module rsa_modexp_param #(
  parameter int KEY_W  = 256,
  parameter int EXP_W  = 256,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              oe,
  input  logic              start,
  input  logic [1:0]        reg_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int SW = KEY_W + 3;
  localparam int CW = $clog2(2*KEY_W + 5);
  localparam int EW = $clog2(EXP_W + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(2*KEY_W + 3);
  localparam logic [CW-1:0] MM_LAST  = CW'(KEY_W + 2);
  localparam logic [EW-1:0] EXP_LAST = EW'(EXP_W - 1);

  typedef enum logic [2:0] {IDLE, PRE, MONT, EXP, OUT} state_t;
  state_t state, state_nxt;

  logic [KEY_W-1:0] m_r, n_r, t_r, x_r, result;
  logic [EXP_W-1:0] e_r, e_sh, e_shifted;
  logic [KEY_W:0]   c_r, pre_nxt;
  logic [KEY_W+1:0] c2;
  logic [SW-1:0]    s0, s1;
  logic [CW-1:0]    cnt;
  logic [EW-1:0]    ebit;
  logic             err_pend;
  logic             op_bad, mm_last, exp_done, exp_skip;
  logic             a0, a1;
  logic [KEY_W-1:0] b0, b1, f0, f1;
  logic [7:0]       rd_byte;

  function automatic logic bit_at(input logic [KEY_W-1:0] v, input logic [CW-1:0] i);
    logic [KEY_W-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  // One Montgomery iteration: add a_i*b, make even with q*N, halve.
  function automatic logic [SW-1:0] mm_step(input logic [SW-1:0] s, input logic a,
                                            input logic [KEY_W-1:0] b, input logic [KEY_W-1:0] n);
    logic [SW-1:0] u;
    u = s + (a ? SW'(b) : '0);
    u = u + (u[0] ? SW'(n) : '0);
    return u >> 1;
  endfunction

  function automatic logic [KEY_W-1:0] mm_fin(input logic [SW-1:0] s, input logic [KEY_W-1:0] n);
    logic [SW-1:0] d;
    d = s - SW'(n);
    return (s >= SW'(n)) ? d[KEY_W-1:0] : s[KEY_W-1:0];
  endfunction

  assign op_bad    = !n_r[0] || (n_r < KEY_W'(3)) || (m_r >= n_r);
  assign mm_last   = (cnt == MM_LAST);
  assign e_shifted = e_sh >> 1;
  assign c2        = {c_r, 1'b0};
  assign pre_nxt   = (c2 >= {2'b00, n_r}) ? (KEY_W+1)'(c2 - {2'b00, n_r}) : c2[KEY_W:0];
  assign f0        = mm_fin(s0, n_r);
  assign f1        = mm_fin(s1, n_r);

`ifdef RSA_EXP_SKIP_EN
  assign exp_done = (e_shifted == '0) || (ebit == EXP_LAST);
  assign exp_skip = (e_sh == '0);
`else
  assign exp_done = (ebit == EXP_LAST);
  assign exp_skip = 1'b0;
`endif

  always_comb begin
    rd_byte = '0;
    for (int b = 0; b < KEY_W/8; b++)
      if (int'(addr) == b) rd_byte = result[8*b +: 8];
  end

  // Operand routing of the two MM units per phase.
  always_comb begin
    a0 = 1'b0;
    a1 = 1'b0;
    b0 = '0;
    b1 = '0;
    case (state)
      MONT: begin
        a0 = bit_at(m_r, cnt);
        a1 = (cnt == '0);
        b0 = c_r[KEY_W-1:0];
        b1 = c_r[KEY_W-1:0];
      end
      EXP: begin
        a0 = bit_at(t_r, cnt);
        a1 = bit_at(x_r, cnt);
        b0 = t_r;
        b1 = t_r;
      end
      OUT: begin
        a1 = bit_at(x_r, cnt);
        b1 = KEY_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !op_bad) state_nxt = PRE;
      PRE:     if (cnt == PRE_LAST) state_nxt = MONT;
      MONT:    if (mm_last) state_nxt = exp_skip ? OUT : EXP;
      EXP:     if (mm_last && exp_done) state_nxt = OUT;
      OUT:     if (mm_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_o <= '0; busy <= 1'b0; done <= 1'b0; err <= 1'b0; err_pend <= 1'b0;
      m_r <= '0; n_r <= '0; e_r <= '0; e_sh <= '0; result <= '0;
      t_r <= '0; x_r <= '0; c_r <= '0; s0 <= '0; s1 <= '0; cnt <= '0; ebit <= '0;
    end else begin
      done     <= err_pend;
      err_pend <= 1'b0;
      if (!we) begin
        if (!busy) begin
          for (int b = 0; b < KEY_W/8; b++)
            if (int'(addr) == b) begin
              if (reg_sel == 2'd1) m_r[8*b +: 8] <= data_i;
              if (reg_sel == 2'd3) n_r[8*b +: 8] <= data_i;
            end
          for (int b = 0; b < EXP_W/8; b++)
            if (int'(addr) == b && reg_sel == 2'd2) e_r[8*b +: 8] <= data_i;
        end
      end else if (!oe && reg_sel == 2'd0) begin
        data_o <= rd_byte;
      end
      case (state)
        IDLE: if (start) begin
          if (op_bad) begin
            err      <= 1'b1;
            err_pend <= 1'b1;
          end else begin
            err  <= 1'b0;
            busy <= 1'b1;
            c_r  <= (KEY_W+1)'(1);
            cnt  <= '0;
            e_sh <= e_r;
            ebit <= '0;
            s0   <= '0;
            s1   <= '0;
          end
        end
        PRE: begin
          c_r <= pre_nxt;
          cnt <= (cnt == PRE_LAST) ? '0 : cnt + 1'b1;
        end
        MONT, EXP, OUT: begin
          if (!mm_last) begin
            s0  <= mm_step(s0, a0, b0, n_r);
            s1  <= mm_step(s1, a1, b1, n_r);
            cnt <= cnt + 1'b1;
          end else begin
            s0  <= '0;
            s1  <= '0;
            cnt <= '0;
            if (state == MONT) begin
              t_r <= f0;
              x_r <= f1;
            end else if (state == EXP) begin
              t_r  <= f0;
              if (e_sh[0]) x_r <= f1;
              e_sh <= e_shifted;
              ebit <= ebit + 1'b1;
            end else begin
              result <= f1;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
